// File: rtl/prefetch_pkg.sv
// rtl/prefetch_pkg.sv - shared types and defaults for the instruction prefetch buffer
package prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_e;

  localparam int          DEF_DEPTH  = 4;
  localparam int          DEF_ADDR_W = 32;
  localparam int          DEF_DATA_W = 32;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - synchronous FIFO with flush; head entry read straight from storage
module prefetch_fifo
  import prefetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_ADDR_W + DEF_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A push at full is only accepted when the same cycle frees a slot.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/prefetch_buffer.sv
// rtl/prefetch_buffer.sv - sequential instruction prefetcher: request FSM, fetch pointer and FIFO
module prefetch_buffer
  import prefetch_pkg::*;
#(
  parameter int                 DEPTH  = DEF_DEPTH,
  parameter int                 ADDR_W = DEF_ADDR_W,
  parameter int                 DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0]  NOP    = DATA_W'(NOP_WORD)
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  input  logic                     advance,
  output logic [DATA_W-1:0]        prefetch,
  output logic [ADDR_W-1:0]        prefetch_pc,
  output logic                     prefetch_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam int W   = ADDR_W + DATA_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;

  logic [W-1:0]      head;
  logic [CW-1:0]     cnt;
  logic              full, empty;
  logic              push, pop_eff;
  logic [ADDR_W-1:0] rpc, fpc_next;
  logic [CW1-1:0]    cnt_after;

  assign rpc       = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign fpc_next  = fpc_q + ADDR_W'(4);
  assign push      = (state_q == REQ) && mem_ack && !redirect;
  assign pop_eff   = advance && !empty;
  assign cnt_after = CW1'(cnt) + CW1'(1) - CW1'(pop_eff);

  prefetch_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .wdata_i ({fpc_q, mem_rdata}),
    .pop_i   (advance),
    .flush_i (redirect),
    .rdata_o (head),
    .count_o (cnt),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    req_addr_d = req_addr_q;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          fpc_d = rpc;
        end else if (cnt < CW'(DEPTH)) begin
          state_d    = REQ;
          req_addr_d = fpc_q;
        end
      end
      REQ: begin
        if (redirect) begin
          // An issued request cannot be withdrawn; DISCARD absorbs its ack.
          fpc_d   = rpc;
          state_d = mem_ack ? IDLE : DISCARD;
        end else if (mem_ack) begin
          fpc_d = fpc_next;
          if (cnt_after < CW1'(DEPTH)) begin
            req_addr_d = fpc_next;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (redirect) fpc_d = rpc;
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fpc_q      <= '0;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign mem_req        = (state_q != IDLE);
  assign mem_addr       = req_addr_q;
  assign prefetch_valid = !empty;
  assign prefetch       = empty ? NOP : head[DATA_W-1:0];
  assign prefetch_pc    = empty ? '0 : head[W-1:DATA_W];
  assign count          = cnt;

endmodule
